iterative_divider: RTL and testbench
====================================

// Module: iterative_divider
// PURPOSE
//  Parametrised multi-cycle restoring divider for the cpu32e2 execute stage: one quotient bit per cycle, signed or unsigned.
//  Owns the full operation: operand capture, sign handling, shift-subtract loop, result fixup and a ready/valid result handshake.
//  Successor to the fixed 32-bit remainder datapath; sits beside the multiplier and is started by the execute control unit.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  startValid   in   1      request a division; accepted when startValid && startReady
//  startReady   out  1      high only in IDLE
//  isSigned     in   1      1 = two's-complement operands, 0 = unsigned; sampled at accept
//  dividend     in   WIDTH  sampled at accept
//  divisor      in   WIDTH  sampled at accept
//  abort        in   1      cancel any in-flight operation (pipeline flush)
//  resultValid  out  1      quotient/remainder/divByZero valid; held until resultReady
//  resultReady  in   1      consumer accepts result when resultValid && resultReady
//  quotient     out  WIDTH  result quotient
//  remainder    out  WIDTH  result remainder
//  divByZero    out  1      divisor was zero (feature-dependent, see CONFIGURATION)
// BEHAVIOUR
//  Reset (sync): state=IDLE, quotient=0, remainder=0, resultValid=0, divByZero=0, count=0; startReady=1 from the first cycle after reset.
//  States: IDLE -> DIVIDE -> FIXUP -> DONE -> IDLE.
//  IDLE: on accept, latch |dividend|, |divisor| (magnitudes if isSigned, raw otherwise), negQ = signed && sign(dd)!=sign(dv), negR = signed && sign(dd), count=WIDTH-1 -> DIVIDE.
//  DIVIDE: per cycle, r' = {r[WIDTH-2:0], dd[WIDTH-1]} - dv using WIDTH+1-bit subtract.
//   If borrow: keep shifted r, shift 0 into quotient; else take difference, shift 1 in. Shift dd left by 1.
//   After WIDTH cycles (count==0) -> FIXUP.
//  FIXUP: quotient = negQ ? -q : q; remainder = negR ? -r : r (WIDTH-bit wrap) -> DONE.
//  DONE: resultValid=1; outputs stable while resultReady=0; on handshake -> IDLE with resultValid=0 next cycle.
//  Latency: accept at cycle t -> resultValid high at t+WIDTH+2; min initiation interval WIDTH+3.
//  Edge cases (mandatory values):
//   - divisor==0: quotient = all ones, remainder = original dividend, any sign mode; FIXUP forces this.
//   - signed MIN/-1: quotient = MIN (wraps), remainder = 0; must fall out of magnitude math without special path.
//   - |divisor| > |dividend|: quotient 0, remainder = dividend.
//  abort: highest priority after reset; in any state -> IDLE next cycle, resultValid=0, in-flight result discarded.
//   abort && startValid in IDLE: request is NOT accepted.
//  startValid outside IDLE ignored (startReady=0). No accept in the DONE handshake cycle.
// CONFIGURATION
//  DIVIDER_ZERO_FAST_EN defined:
//   - zero divisor detected at accept -> state DONE directly; resultValid at t+1.
//   - Result per edge-case rule; divByZero=1 with that result.
//  Not defined:
//   - zero divisor runs the full loop (latency t+WIDTH+2), same quotient/remainder; divByZero tied 0.
// STRUCTURE
//  New package divider3Pkg:
//   - enum divState {IDLE, DIVIDE, FIXUP, DONE}
//   - enum remainderMux {RESET_REMAINDER, LOAD_REMAINDER, SHIFTED_REMAINDER, SUBTRACTED_REMAINDER}
//   - localparam helper for counter width $clog2(WIDTH)
//  Sub-module divider_step (combinational, parametrised WIDTH): inputs r, dd msb, dv; outputs next r and quotient bit.
//  Top holds FSM, counter, operand/sign registers, output registers.
// TESTING (WIDTH=32 unless noted)
//  1. Unsigned 100/7, accept t -> resultValid at t+34, q=14, r=2, divByZero=0.
//  2. Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1; unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
//  3. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 5/0 -> q=0xFFFFFFFF, r=5; resultValid at t+1 with macro (divByZero=1), t+34 without.
//  4. Hold resultReady=0 for 5 cycles after resultValid -> outputs/resultValid unchanged; handshake -> startReady=1 next cycle.
//  5. abort at t+10, then reset at t+10 on a second run -> both: resultValid never asserts, startReady=1 at t+11; new 9/3 gives q=3, r=0.
//  6. WIDTH=8 random signed/unsigned sweep vs reference model -> all results match, latency 10 cycles.

Source files
------------

// File: rtl/iterative_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package iterative_divider_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FIXUP  = 2'd2,
      DONE   = 2'd3
   } divState;

   typedef enum logic [1:0] {
      RESET_REMAINDER      = 2'd0,
      LOAD_REMAINDER       = 2'd1,
      SHIFTED_REMAINDER    = 2'd2,
      SUBTRACTED_REMAINDER = 2'd3
   } remainderMux;

   function automatic int count_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// Start/result handshake bundle between the execute control unit and the divider.
interface iterative_divider_if #(parameter int WIDTH = 32);
   logic             startValid;
   logic             startReady;
   logic             isSigned;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             abort;
   logic             resultValid;
   logic             resultReady;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             divByZero;

   modport master (
      output startValid, isSigned, dividend, divisor, abort, resultReady,
      input  startReady, resultValid, quotient, remainder, divByZero
   );

   modport slave (
      input  startValid, isSigned, dividend, divisor, abort, resultReady,
      output startReady, resultValid, quotient, remainder, divByZero
   );
endinterface

// File: rtl/iterative_divider_step.sv
// One restoring shift-subtract step: produces the next partial remainder and quotient bit.
module iterative_divider_step
   import iterative_divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dd_msb,
   input  logic [WIDTH-1:0] dv,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   remainderMux    sel;

   // Trial subtraction; a set shifted msb already exceeds any divisor.
   always_comb begin
      shifted = {rem, dd_msb};
      diff    = shifted - {1'b0, dv};
      q_bit   = shifted[WIDTH] | ~diff[WIDTH];
      if (q_bit) begin
         sel = SUBTRACTED_REMAINDER;
      end else begin
         sel = SHIFTED_REMAINDER;
      end
      case (sel)
         SUBTRACTED_REMAINDER: next_rem = diff[WIDTH-1:0];
         SHIFTED_REMAINDER:    next_rem = shifted[WIDTH-1:0];
         default:              next_rem = {WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned restoring divider with ready/valid result handshake.
// Optional DIVIDER_ZERO_FAST_EN: zero divisor skips the loop and flags divByZero.
module iterative_divider
   import iterative_divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   iterative_divider_if.slave bus
);

   localparam int CW = count_width(WIDTH);
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   divState          state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dd_r, dv_r, rem_r, quo_r, orig_dd_r;
   logic             neg_q_r, neg_r_r, dv_zero_r;
   logic [WIDTH-1:0] quotient_r, remainder_r;
   logic             result_valid_r, div_by_zero_r;
   logic             accept, done_hs, in_zero, q_bit;
   logic [WIDTH-1:0] dd_abs, dv_abs, rem_step;

   iterative_divider_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_r),
      .dd_msb   (dd_r[WIDTH-1]),
      .dv       (dv_r),
      .next_rem (rem_step),
      .q_bit    (q_bit)
   );

   // Handshake decode and operand magnitudes.
   always_comb begin
      accept  = bus.startValid && (state == IDLE) && !bus.abort;
      done_hs = result_valid_r && bus.resultReady;
      in_zero = (bus.divisor == ZERO);
      if (bus.isSigned && bus.dividend[WIDTH-1]) begin
         dd_abs = ~bus.dividend + ONE;
      end else begin
         dd_abs = bus.dividend;
      end
      if (bus.isSigned && bus.divisor[WIDTH-1]) begin
         dv_abs = ~bus.divisor + ONE;
      end else begin
         dv_abs = bus.divisor;
      end
   end

   // FSM next-state logic; abort overrides every state.
   always_comb begin
      state_next = state;
      if (bus.abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
`ifdef DIVIDER_ZERO_FAST_EN
                  state_next = in_zero ? DONE : DIVIDE;
`else
                  state_next = DIVIDE;
`endif
               end else begin
                  state_next = IDLE;
               end
            end
            DIVIDE: begin
               if (count == {CW{1'b0}}) begin
                  state_next = FIXUP;
               end else begin
                  state_next = DIVIDE;
               end
            end
            FIXUP:   state_next = DONE;
            DONE: begin
               if (done_hs) begin
                  state_next = IDLE;
               end else begin
                  state_next = DONE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand capture and shift-subtract loop.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= {CW{1'b0}};
         dd_r      <= ZERO;
         dv_r      <= ZERO;
         rem_r     <= ZERO;
         quo_r     <= ZERO;
         orig_dd_r <= ZERO;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         dv_zero_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dd_r      <= dd_abs;
                  dv_r      <= dv_abs;
                  rem_r     <= ZERO;
                  quo_r     <= ZERO;
                  orig_dd_r <= bus.dividend;
                  neg_q_r   <= bus.isSigned && (bus.dividend[WIDTH-1] != bus.divisor[WIDTH-1]);
                  neg_r_r   <= bus.isSigned && bus.dividend[WIDTH-1];
                  dv_zero_r <= in_zero;
                  count     <= CW'(WIDTH - 1);
               end
            end
            DIVIDE: begin
               rem_r <= rem_step;
               quo_r <= {quo_r[WIDTH-2:0], q_bit};
               dd_r  <= {dd_r[WIDTH-2:0], 1'b0};
               count <= count - {{(CW-1){1'b0}}, 1'b1};
            end
            default: ;
         endcase
      end
   end

   // Result registers; zero divisor forces all-ones quotient and original dividend.
   always_ff @(posedge clk) begin
      if (reset) begin
         quotient_r     <= ZERO;
         remainder_r    <= ZERO;
         result_valid_r <= 1'b0;
         div_by_zero_r  <= 1'b0;
      end else if (bus.abort) begin
         result_valid_r <= 1'b0;
      end else begin
         case (state)
`ifdef DIVIDER_ZERO_FAST_EN
            IDLE: begin
               if (accept && in_zero) begin
                  quotient_r     <= ONES;
                  remainder_r    <= bus.dividend;
                  div_by_zero_r  <= 1'b1;
                  result_valid_r <= 1'b1;
               end
            end
`endif
            FIXUP: begin
               if (dv_zero_r) begin
                  quotient_r  <= ONES;
                  remainder_r <= orig_dd_r;
               end else begin
                  quotient_r  <= neg_q_r ? (~quo_r + ONE) : quo_r;
                  remainder_r <= neg_r_r ? (~rem_r + ONE) : rem_r;
               end
               div_by_zero_r  <= 1'b0;
               result_valid_r <= 1'b1;
            end
            DONE: begin
               if (done_hs) begin
                  result_valid_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.startReady  = (state == IDLE);
   assign bus.resultValid = result_valid_r;
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.divByZero   = div_by_zero_r;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench: 32-bit vector table, abort/reset sequences, 8-bit random sweep.
module tb_iterative_divider;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

`ifdef DIVIDER_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   iterative_divider_if #(.WIDTH(32)) if32 ();
   iterative_divider_if #(.WIDTH(8))  if8 ();

   iterative_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
   iterative_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

   typedef struct {
      logic        s;
      logic [31:0] dd;
      logic [31:0] dv;
      logic [31:0] q;
      logic [31:0] r;
      int          hold;
   } vec32_t;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run32(input vec32_t v);
      exp_t e;
      int   lat;
      bit   got;
      @(negedge clk);
      chk("start_ready_idle", 64'(if32.startReady), 64'(1));
      if32.startValid = 1'b1;
      if32.isSigned   = v.s;
      if32.dividend   = v.dd;
      if32.divisor    = v.dv;
      e.q   = v.q;
      e.r   = v.r;
      e.dz  = FAST && (v.dv == 32'd0);
      e.lat = (FAST && (v.dv == 32'd0)) ? 1 : 34;
      sb.push_back(e);
      @(posedge clk);
      #1 if32.startValid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk("start_ready_busy", 64'(if32.startReady), 64'(0));
         if (if32.resultValid) got = 1'b1;
      end
      chk("result_seen", 64'(got), 64'(1));
      e = sb.pop_front();
      chk("latency32", 64'(lat), 64'(e.lat));
      chk("quotient32", 64'(if32.quotient), 64'(e.q));
      chk("remainder32", 64'(if32.remainder), 64'(e.r));
      chk("div_by_zero32", 64'(if32.divByZero), 64'(e.dz));
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(if32.resultValid), 64'(1));
         chk("hold_result", {if32.quotient, if32.remainder}, {e.q, e.r});
      end
      if32.resultReady = 1'b1;
      @(posedge clk);
      #1 if32.resultReady = 1'b0;
      @(negedge clk);
      chk("valid_drop", 64'(if32.resultValid), 64'(0));
      chk("ready_after_hs", 64'(if32.startReady), 64'(1));
   endtask

   task automatic abort_run(input bit use_reset);
      bit seen;
      @(negedge clk);
      if32.startValid = 1'b1;
      if32.isSigned   = 1'b0;
      if32.dividend   = 32'd100;
      if32.divisor    = 32'd7;
      @(posedge clk);
      #1 if32.startValid = 1'b0;
      for (int c = 1; c <= 10; c++) @(negedge clk);
      if (use_reset) reset = 1'b1;
      else if32.abort = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      if32.abort = 1'b0;
      @(negedge clk);
      chk(use_reset ? "reset_ready" : "abort_ready", 64'(if32.startReady), 64'(1));
      chk(use_reset ? "reset_valid" : "abort_valid", 64'(if32.resultValid), 64'(0));
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (if32.resultValid) seen = 1'b1;
      end
      chk("no_result_after_cancel", 64'(seen), 64'(0));
   endtask

   function automatic void ref8(input logic s, input logic [7:0] dd, input logic [7:0] dv,
                                output logic [7:0] q, output logic [7:0] r);
      int a, b, qi, ri;
      if (dv == 8'd0) begin
         q = 8'hFF;
         r = dd;
      end else begin
         if (s) begin
            a = int'($signed(dd));
            b = int'($signed(dv));
         end else begin
            a = int'({24'd0, dd});
            b = int'({24'd0, dv});
         end
         qi = a / b;
         ri = a % b;
         q = qi[7:0];
         r = ri[7:0];
      end
   endfunction

   task automatic run8(input logic s, input logic [7:0] dd, input logic [7:0] dv);
      exp_t       e;
      logic [7:0] q, r;
      int         lat;
      bit         got;
      ref8(s, dd, dv, q, r);
      @(negedge clk);
      if8.startValid = 1'b1;
      if8.isSigned   = s;
      if8.dividend   = dd;
      if8.divisor    = dv;
      e.q   = {24'd0, q};
      e.r   = {24'd0, r};
      e.dz  = FAST && (dv == 8'd0);
      e.lat = (FAST && (dv == 8'd0)) ? 1 : 10;
      sb.push_back(e);
      @(posedge clk);
      #1 if8.startValid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 50) begin
         @(negedge clk);
         lat++;
         if (if8.resultValid) got = 1'b1;
      end
      e = sb.pop_front();
      chk("latency8", 64'(lat), 64'(e.lat));
      chk("result8", {if8.quotient, if8.remainder, 7'd0, if8.divByZero},
          {e.q[7:0], e.r[7:0], 7'd0, e.dz});
      if8.resultReady = 1'b1;
      @(posedge clk);
      #1 if8.resultReady = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec32_t tbl[12];
      logic [7:0] dd8, dv8;
      tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          5};
      tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0};
      tbl[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0};
      tbl[3]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          0};
      tbl[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0};
      tbl[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          0};
      tbl[6]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          0};
      tbl[7]  = '{1'b1, 32'hFFFFFFFD,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFD,   0};
      tbl[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   0};
      tbl[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          0};
      tbl[10] = '{1'b0, 32'h80000000,   32'hC0000000,   32'd0,          32'h80000000,   0};
      tbl[11] = '{1'b0, 32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   0};

      if32.startValid = 1'b0; if32.isSigned = 1'b0; if32.dividend = 32'd0;
      if32.divisor = 32'd0; if32.abort = 1'b0; if32.resultReady = 1'b0;
      if8.startValid = 1'b0;  if8.isSigned = 1'b0;  if8.dividend = 8'd0;
      if8.divisor = 8'd0;  if8.abort = 1'b0;  if8.resultReady = 1'b0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_start_ready", 64'(if32.startReady), 64'(1));
      chk("reset_result_valid", 64'(if32.resultValid), 64'(0));
      chk("reset_outputs", {if32.quotient, if32.remainder}, 64'd0);
      chk("reset_div_by_zero", 64'(if32.divByZero), 64'(0));

      for (int i = 0; i < 12; i++) run32(tbl[i]);

      // abort together with a start request in IDLE must not accept it
      @(negedge clk);
      if32.startValid = 1'b1;
      if32.abort      = 1'b1;
      if32.dividend   = 32'd9;
      if32.divisor    = 32'd3;
      @(posedge clk);
      #1;
      if32.startValid = 1'b0;
      if32.abort      = 1'b0;
      @(negedge clk);
      chk("abort_blocks_accept", 64'(if32.startReady), 64'(1));

      abort_run(1'b0);
      abort_run(1'b1);
      run32('{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0});

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(3, 0))
            0:       dd8 = 8'h80;
            default: dd8 = 8'($urandom_range(255, 0));
         endcase
         case ($urandom_range(7, 0))
            0:       dv8 = 8'h00;
            1:       dv8 = 8'hFF;
            default: dv8 = 8'($urandom_range(255, 0));
         endcase
         run8(1'($urandom_range(1, 0)), dd8, dv8);
      end
      run8(1'b1, 8'h80, 8'hFF);
      run8(1'b0, 8'd7, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
